// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing one config write port.
// Each channel produces a square wave of period 2*(div+1) and a wrap tick.
module clk_div_bank #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned DEFAULT_DIV = 49999999
) (
    input  logic                 clk50,
    input  logic                 rst_n,
    input  logic [CHANNELS-1:0]  en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [3:0]           cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    output logic                 cfg_err,
    output logic [CHANNELS-1:0]  clkout,
    output logic [CHANNELS-1:0]  tick
);

    logic [CHANNELS-1:0] pend;
    logic                cfg_accept;
    logic                ch_valid;

    assign ch_valid   = {1'b0, cfg_ch} < 5'(CHANNELS);
    assign cfg_accept = cfg_valid && cfg_ready;

    // A channel holding an unapplied value refuses further writes until it wraps.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == 4'(i) && pend[i]) begin
                cfg_ready = 1'b0;
            end
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_accept && !ch_valid;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] div;
        logic [CNT_WIDTH-1:0] pdiv;
        logic                 pend_q;
        logic                 clk_q;
        logic                 tick_q;
        logic                 hit;
        logic                 wrap;

        assign hit  = cfg_accept && ch_valid && (cfg_ch == 4'(g));
        assign wrap = (cnt == div);

        // Staging register for the next divide value; only meaningful while pend_q is set.
        always_ff @(posedge clk50) begin
            if (hit && en[g]) begin
                pdiv <= cfg_div;
            end
        end

        always_ff @(posedge clk50 or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                div    <= CNT_WIDTH'(DEFAULT_DIV);
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (!en[g]) begin
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                if (pend_q) begin
                    div    <= pdiv;
                    pend_q <= 1'b0;
                end else if (hit) begin
                    div <= cfg_div;
                end
            end else begin
                if (wrap) begin
                    cnt    <= '0;
                    clk_q  <= ~clk_q;
                    tick_q <= 1'b1;
                    if (pend_q) begin
                        div    <= pdiv;
                        pend_q <= 1'b0;
                    end
                end else begin
                    cnt    <= cnt + CNT_WIDTH'(1);
                    tick_q <= 1'b0;
                end
                // hit implies pend_q was clear, so a write landing on a wrap waits for the next one.
                if (hit) begin
                    pend_q <= 1'b1;
                end
            end
        end

        assign pend[g]   = pend_q;
        assign clkout[g] = clk_q;
        assign tick[g]   = tick_q;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with two 8-bit channels, default divide 3.
module tb_clk_div_bank;

    logic       clk50 = 1'b0;
    logic       rst_n;
    logic [1:0] en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_err;
    logic [1:0] clkout;
    logic [1:0] tick;

    int total = 0;
    int bad   = 0;
    int tk0, tk1, tg0, tg1;

    clk_div_bank #(
        .CHANNELS   (2),
        .CNT_WIDTH  (8),
        .DEFAULT_DIV(3)
    ) dut (
        .clk50    (clk50),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_err  (cfg_err),
        .clkout   (clkout),
        .tick     (tick)
    );

    always #5 clk50 = ~clk50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    task automatic run_count(input int n, output int t0, output int t1,
                             output int g0, output int g1);
        logic [1:0] prev;
        t0 = 0; t1 = 0; g0 = 0; g1 = 0;
        for (int i = 0; i < n; i++) begin
            prev = clkout;
            step();
            if (tick[0]) t0++;
            if (tick[1]) t1++;
            if (clkout[0] != prev[0]) g0++;
            if (clkout[1] != prev[1]) g1++;
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 2'b00; cfg_valid = 1'b0; cfg_ch = 4'd0; cfg_div = 8'd0;
        repeat (2) step();
        check("rst_clkout", 32'(clkout), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);

        // Both channels at default divide 3: wrap on every 4th edge.
        rst_n = 1'b1; en = 2'b11;
        repeat (3) step();
        check("e3_clkout", 32'(clkout), 32'd0);
        check("e3_tick", 32'(tick), 32'd0);
        step();
        check("e4_clkout", 32'(clkout), 32'd3);
        check("e4_tick", 32'(tick), 32'd3);
        step();
        check("e5_clkout", 32'(clkout), 32'd3);
        check("e5_tick", 32'(tick), 32'd0);
        repeat (3) step();
        check("e8_clkout", 32'(clkout), 32'd0);
        check("e8_tick", 32'(tick), 32'd3);
        run_count(8, tk0, tk1, tg0, tg1);
        check("def_tk0", 32'(tk0), 32'd2);
        check("def_tk1", 32'(tk1), 32'd2);
        check("def_tg0", 32'(tg0), 32'd2);
        check("def_tg1", 32'(tg1), 32'd2);

        // Ch0 at cnt=1: pending write of 1 applies at the cnt=3 wrap.
        step();
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_div = 8'd1;
        check("w0_ready_pre", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        check("w0_ready_pend", 32'(cfg_ready), 32'd0);
        step();
        check("w0_ready_e19", 32'(cfg_ready), 32'd0);
        check("w0_clk_e19", 32'(clkout[0]), 32'd0);
        step();
        check("w0_clk_wrap", 32'(clkout[0]), 32'd1);
        check("w0_tick_wrap", 32'(tick[0]), 32'd1);
        check("w0_ready_post", 32'(cfg_ready), 32'd1);
        step();
        check("w0_clk_e21", 32'(clkout[0]), 32'd1);
        check("w0_tick_e21", 32'(tick[0]), 32'd0);
        step();
        check("w0_clk_e22", 32'(clkout[0]), 32'd0);
        check("w0_tick_e22", 32'(tick[0]), 32'd1);
        run_count(8, tk0, tk1, tg0, tg1);
        check("div1_tk0", 32'(tk0), 32'd4);
        check("div1_tg0", 32'(tg0), 32'd4);
        check("div1_tk1", 32'(tk1), 32'd2);
        check("div1_tg1", 32'(tg1), 32'd2);

        // Ch1 write of 0 in its wrap cycle: one more full half-period first.
        step();
        cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_div = 8'd0;
        check("w1_ready_pre", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        check("w1_clk_wrap", 32'(clkout[1]), 32'd0);
        check("w1_tick_wrap", 32'(tick[1]), 32'd1);
        check("w1_ready_pend", 32'(cfg_ready), 32'd0);
        step();
        check("w1_tick_e33", 32'(tick[1]), 32'd0);
        repeat (2) step();
        check("w1_clk_e35", 32'(clkout[1]), 32'd0);
        check("w1_tick_e35", 32'(tick[1]), 32'd0);
        step();
        check("w1_clk_e36", 32'(clkout[1]), 32'd1);
        check("w1_tick_e36", 32'(tick[1]), 32'd1);
        check("w1_ready_e36", 32'(cfg_ready), 32'd1);
        step();
        check("w1_clk_e37", 32'(clkout[1]), 32'd0);
        check("w1_tick_e37", 32'(tick[1]), 32'd1);
        run_count(8, tk0, tk1, tg0, tg1);
        check("div0_tk1", 32'(tk1), 32'd8);
        check("div0_tg1", 32'(tg1), 32'd8);
        check("div0_tk0", 32'(tk0), 32'd4);
        check("div0_tg0", 32'(tg0), 32'd4);

        // Disabled ch1 takes a direct load of 5.
        en = 2'b01;
        step();
        check("dis_clk1", 32'(clkout[1]), 32'd0);
        check("dis_tick1", 32'(tick[1]), 32'd0);
        cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_div = 8'd5;
        step();
        cfg_valid = 1'b0;
        check("dis_ready", 32'(cfg_ready), 32'd1);
        check("dis_tick1_e47", 32'(tick[1]), 32'd0);
        en = 2'b11;
        repeat (5) step();
        check("div5_clk_e52", 32'(clkout[1]), 32'd0);
        check("div5_tick_e52", 32'(tick[1]), 32'd0);
        step();
        check("div5_clk_e53", 32'(clkout[1]), 32'd1);
        check("div5_tick_e53", 32'(tick[1]), 32'd1);

        // Write to a non-existent channel.
        cfg_valid = 1'b1; cfg_ch = 4'd7; cfg_div = 8'd0;
        check("bad_ready", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        check("bad_err_on", 32'(cfg_err), 32'd1);
        step();
        check("bad_err_off", 32'(cfg_err), 32'd0);
        run_count(8, tk0, tk1, tg0, tg1);
        check("bad_tk0", 32'(tk0), 32'd4);
        check("bad_tg0", 32'(tg0), 32'd4);
        check("bad_tk1", 32'(tk1), 32'd1);
        check("bad_tg1", 32'(tg1), 32'd1);

        // Ch1 disabled while a write of 2 is pending: applied while idle.
        cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_div = 8'd2;
        step();
        cfg_valid = 1'b0; en = 2'b01;
        check("dpend_ready", 32'(cfg_ready), 32'd0);
        step();
        check("dpend_ready_clr", 32'(cfg_ready), 32'd1);
        check("dpend_clk1", 32'(clkout[1]), 32'd0);
        en = 2'b11;
        repeat (2) step();
        check("div2_clk_e67", 32'(clkout[1]), 32'd0);
        step();
        check("div2_clk_e68", 32'(clkout[1]), 32'd1);

        // Reset mid-period with ch0 pending.
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_div = 8'd2;
        step();
        cfg_valid = 1'b0;
        check("rp_ready", 32'(cfg_ready), 32'd0);
        check("rp_clk1_pre", 32'(clkout[1]), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_clkout", 32'(clkout), 32'd0);
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_err", 32'(cfg_err), 32'd0);
        check("arst_ready", 32'(cfg_ready), 32'd1);
        repeat (2) step();
        rst_n = 1'b1; en = 2'b11;
        check("rel_ready", 32'(cfg_ready), 32'd1);
        repeat (3) step();
        check("rel_clk_r3", 32'(clkout), 32'd0);
        step();
        check("rel_clk_r4", 32'(clkout), 32'd3);
        check("rel_tick_r4", 32'(tick), 32'd3);
        repeat (3) step();
        check("rel_clk_r7", 32'(clkout), 32'd3);
        check("rel_tick_r7", 32'(tick), 32'd0);
        step();
        check("rel_clk_r8", 32'(clkout), 32'd0);
        check("rel_tick_r8", 32'(tick), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of each divide value and counter.
REQ-003 SHALL have parameter DEFAULT_DIV, default 49999999, divide value loaded into every channel at reset.
REQ-004 SHALL have port clk50  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  CHANNELS  per-channel run enable.
REQ-007 SHALL have port cfg_valid  input  1  config write request.
REQ-008 SHALL have port cfg_ready  output  1  config write can be accepted this cycle.
REQ-009 SHALL have port cfg_ch  input  4  target channel index.
REQ-010 SHALL have port cfg_div  input  CNT_WIDTH  new divide value.
REQ-011 SHALL have port cfg_err  output  1  one-cycle pulse: accepted write targeted a non-existent channel.
REQ-012 SHALL have port clkout  output  CHANNELS  per-channel square wave.
REQ-013 SHALL have port tick  output  CHANNELS  per-channel one-cycle pulse at each wrap.

Function
REQ-014 Each channel SHALL hold a counter cnt, active divide value div, pending value pdiv and pending flag pend.
REQ-015 Enabled channel: if cnt == div then cnt <= 0, clkout toggles, tick = 1 in the next cycle; else cnt <= cnt+1, tick = 0.
REQ-016 Output period SHALL be 2*(div+1) clk50 cycles; tick period (div+1) cycles; div = 0 gives clkout toggling every cycle and tick constantly 1.
REQ-017 Counter arithmetic SHALL be unsigned CNT_WIDTH; no wrap past div occurs, since cnt never exceeds div.
REQ-018 Disabled channel (en bit 0): cnt held at 0, clkout forced 0, tick 0, registered; re-enabling starts counting from cnt = 0 with clkout = 0.
REQ-019 A write SHALL be accepted when cfg_valid && cfg_ready at a rising edge.
REQ-020 cfg_ready SHALL be combinational: 0 only when cfg_ch < CHANNELS and that channel's pend = 1; otherwise 1.
REQ-021 Accepted write to an enabled channel SHALL set pdiv <= cfg_div, pend <= 1; the value becomes div on that channel's next wrap (cnt reset to 0 at the same edge) and pend clears; no truncated or extended half-period occurs.
REQ-022 A write accepted in the same cycle as the channel's wrap SHALL NOT apply at that wrap; it applies at the following wrap.
REQ-023 Accepted write to a disabled channel SHALL load div directly in one cycle, pend stays 0.
REQ-024 A channel disabled while pend = 1 SHALL apply pdiv to div on the next edge and clear pend.
REQ-025 Accepted write with cfg_ch >= CHANNELS SHALL change no channel state and assert cfg_err for exactly one cycle.
REQ-026 All outputs except cfg_ready SHALL be registered; channels SHALL be fully independent apart from the shared config port.

Reset
REQ-027 While rst_n = 0, asynchronously: every cnt = 0, div = DEFAULT_DIV, pend = 0, clkout = 0, tick = 0, cfg_err = 0.
REQ-028 After rst_n rises, the first increment SHALL occur on the first rising clk50 edge; a reset asserted mid-period SHALL discard pending writes.

Verification
REQ-029 CHANNELS=2, CNT_WIDTH=8, DEFAULT_DIV=3, en=2'b11 after reset -> clkout toggles every 4 cycles (period 8), tick high 1 of every 4 cycles on both channels.
REQ-030 Ch0 at cnt=1 with div=3, write cfg_div=1 -> ch0 completes current half-period (wraps at cnt=3), then toggles every 2 cycles; cfg_ready to ch0 low from acceptance until that wrap.
REQ-031 Write to ch1 in the exact cycle ch1 wraps (cnt=div=3) with cfg_div=0 -> one more 4-cycle half-period, then clkout toggles every cycle, tick stuck at 1.
REQ-032 en=2'b01, write ch1 cfg_div=5 -> div updates next cycle, pend never set; set en[1]=1 -> first clkout rise after 6 cycles.
REQ-033 Write cfg_ch=7 with CHANNELS=2 -> cfg_ready=1, cfg_err high exactly one cycle, both channels' timing unchanged.
REQ-034 Assert rst_n=0 mid-period with ch0 pending -> all outputs 0 immediately without a clock edge; after release, div=3 and pend=0 on both channels.
